// File: rtl/serial_word_mac.sv
// serial_word_mac: word-serial multiply-accumulate stage.
// Accepts N words of M bits, one per handshake, multiplies word k by
// coefficient word k (latched on start) and presents the N-term dot product.
// Build option: define SERIAL_MAC_SIGNED_EN for two's-complement operands;
// the default build treats all operands as unsigned.
module serial_word_mac #(
  parameter int N     = 4,
  parameter int M     = 8,
  parameter int ACC_W = 2 * M + $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N*M-1:0]     coeff_data,
  input  logic               in_valid,
  input  logic [M-1:0]       in_data,
  output logic               in_ready,
  output logic               out_valid,
  output logic [ACC_W-1:0]   out_data,
  input  logic               out_ready,
  output logic               busy
);

  localparam int CNT_W = $clog2(N);
  localparam int EXT_W = ACC_W - 2 * M;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Full-width product of one data word and one coefficient word, extended
  // to the accumulator width (sign- or zero-extension depending on build).
  function automatic logic [ACC_W-1:0] mul_ext(input logic [M-1:0] a,
                                               input logic [M-1:0] b);
    logic [2*M-1:0] ax;
    logic [2*M-1:0] bx;
    logic [2*M-1:0] p;
    logic           ext_bit;
`ifdef SERIAL_MAC_SIGNED_EN
    ax      = {{M{a[M-1]}}, a};
    bx      = {{M{b[M-1]}}, b};
    p       = ax * bx;
    ext_bit = p[2*M-1];
`else
    ax      = {{M{1'b0}}, a};
    bx      = {{M{1'b0}}, b};
    p       = ax * bx;
    ext_bit = 1'b0;
`endif
    return {{EXT_W{ext_bit}}, p};
  endfunction

  state_t             state_r,     state_s;
  logic [ACC_W-1:0]   acc_r,       acc_s;
  logic [CNT_W-1:0]   cnt_r,       cnt_s;
  logic [N*M-1:0]     coeff_r,     coeff_s;
  logic [ACC_W-1:0]   out_data_r,  out_data_s;
  logic               out_valid_r, out_valid_s;
  logic               in_ready_r,  in_ready_s;
  logic               busy_r,      busy_s;

  logic               accept_s;
  logic [M-1:0]       coeff_sel_s;
  logic [ACC_W-1:0]   sum_s;

  assign accept_s    = in_valid && in_ready_r;
  assign coeff_sel_s = coeff_r[cnt_r*M +: M];
  assign sum_s       = acc_r + mul_ext(in_data, coeff_sel_s);

  // Next-state, datapath and next-output computation.
  always_comb begin
    state_s     = state_r;
    acc_s       = acc_r;
    cnt_s       = cnt_r;
    coeff_s     = coeff_r;
    out_data_s  = out_data_r;
    out_valid_s = 1'b0;
    in_ready_s  = 1'b0;
    busy_s      = 1'b0;

    case (state_r)
      IDLE: begin
        if (start) begin
          coeff_s = coeff_data;
          acc_s   = {ACC_W{1'b0}};
          cnt_s   = {CNT_W{1'b0}};
          state_s = ACCUM;
        end else begin
          state_s = IDLE;
        end
      end
      ACCUM: begin
        if (accept_s) begin
          acc_s = sum_s;
          cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_r == CNT_W'(N - 1)) begin
            out_data_s = sum_s;
            state_s    = DONE;
          end else begin
            state_s = ACCUM;
          end
        end else begin
          state_s = ACCUM;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    // Handshake outputs are registered copies decoded from the next state.
    case (state_s)
      IDLE: begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        busy_s      = 1'b0;
      end
      ACCUM: begin
        in_ready_s  = 1'b1;
        out_valid_s = 1'b0;
        busy_s      = 1'b1;
      end
      DONE: begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b1;
        busy_s      = 1'b1;
      end
      default: begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        busy_s      = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers; reset discards any partial result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      acc_r       <= {ACC_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      coeff_r     <= {(N*M){1'b0}};
      out_data_r  <= {ACC_W{1'b0}};
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      acc_r       <= acc_s;
      cnt_r       <= cnt_s;
      coeff_r     <= coeff_s;
      out_data_r  <= out_data_s;
      out_valid_r <= out_valid_s;
      in_ready_r  <= in_ready_s;
      busy_r      <= busy_s;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_serial_word_mac.sv
// Scoreboard bench for serial_word_mac: stimulus pushes the hand-computed
// dot product; a negedge monitor pops and compares on each result hand-off.
module tb_serial_word_mac;

  localparam int N     = 4;
  localparam int M     = 8;
  localparam int ACC_W = 18;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [N*M-1:0]   coeff_data;
  logic             in_valid;
  logic [M-1:0]     in_data;
  logic             in_ready;
  logic             out_valid;
  logic [ACC_W-1:0] out_data;
  logic             out_ready;
  logic             busy;

  int               total    = 0;
  int               passed   = 0;
  int               accepts  = 0;
  int               handoffs = 0;
  logic [ACC_W-1:0] exp_q[$];

  serial_word_mac #(.N(N), .M(M), .ACC_W(ACC_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .coeff_data (coeff_data),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Monitor: counts accepted words and scores every result hand-off.
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) accepts++;
      if (out_valid && out_ready) begin
        handoffs++;
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL sb_underflow: got result %0d, expected no result", out_data);
        end else begin
          check("result", 32'(out_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  function automatic logic [31:0] pack4(input logic [7:0] a0, input logic [7:0] a1,
                                        input logic [7:0] a2, input logic [7:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_dot(input logic [N*M-1:0] c);
    start      = 1'b1;
    coeff_data = c;
    tick();
    start      = 1'b0;
    coeff_data = ~c;
  endtask

  task automatic feed(input logic [M-1:0] d, input bit gap);
    if (gap) begin
      in_valid = 1'b0;
      in_data  = 8'hAA;
      tick();
    end
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic handoff(input string name);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, "_idle_valid"}, 32'(out_valid), 32'd0);
    check({name, "_idle_busy"},  32'(busy),      32'd0);
  endtask

  task automatic run_dot(input string name, input logic [31:0] c, input logic [31:0] d,
                         input bit gap, input logic [ACC_W-1:0] exp_val);
    int a0;
    logic [31:0] dv;
    dv = d;
    a0 = accepts;
    exp_q.push_back(exp_val);
    start_dot(c);
    for (int i = 0; i < N; i++) begin
      feed(dv[i*8 +: 8], gap);
      if (i == N - 2) check({name, "_early_valid"}, 32'(out_valid), 32'd0);
    end
    check({name, "_latency_valid"}, 32'(out_valid), 32'd1);
    check({name, "_done_ready"},    32'(in_ready),  32'd0);
    check({name, "_done_busy"},     32'(busy),      32'd1);
    check({name, "_accepts"},       32'(accepts - a0), 32'd4);
    handoff(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    coeff_data = '0;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b0;
    tick();
    tick();
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    rst = 1'b0;
    tick();

    // 1*10 + 2*20 + 3*30 + 4*40 = 300
    run_dot("cont", pack4(8'd1, 8'd2, 8'd3, 8'd4), pack4(8'd10, 8'd20, 8'd30, 8'd40), 1'b0, 18'd300);
    run_dot("gap",  pack4(8'd1, 8'd2, 8'd3, 8'd4), pack4(8'd10, 8'd20, 8'd30, 8'd40), 1'b1, 18'd300);
`ifdef SERIAL_MAC_SIGNED_EN
    // (-1)*(-1) * 4 = 4
    run_dot("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 18'd4);
`else
    // 255*255 * 4 = 260100
    run_dot("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 18'd260100);
`endif

    // Hold test: 5*1 + 6*2 + 7*3 + 8*4 = 70; start in ACCUM/DONE is ignored.
    exp_q.push_back(18'd70);
    start_dot(pack4(8'd5, 8'd6, 8'd7, 8'd8));
    feed(8'd1, 1'b0);
    start      = 1'b1;
    coeff_data = pack4(8'd9, 8'd9, 8'd9, 8'd9);
    feed(8'd2, 1'b0);
    start      = 1'b0;
    feed(8'd3, 1'b0);
    feed(8'd4, 1'b0);
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_data",  32'(out_data),  32'd70);
      check("hold_ready", 32'(in_ready),  32'd0);
      tick();
    end
    start = 1'b0;
    handoff("hold");
    tick();
    check("hold_stays_idle", 32'(busy), 32'd0);

    // Abort mid-operation with reset: no result, outputs cleared at once.
    start_dot(pack4(8'd1, 8'd2, 8'd3, 8'd4));
    feed(8'd10, 1'b0);
    feed(8'd20, 1'b0);
    rst = 1'b1;
    #1;
    check("abort_in_ready",  32'(in_ready),  32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_busy",      32'(busy),      32'd0);
    check("abort_out_data",  32'(out_data),  32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    run_dot("ones", pack4(8'd1, 8'd1, 8'd1, 8'd1), pack4(8'd1, 8'd1, 8'd1, 8'd1), 1'b0, 18'd4);

`ifdef SERIAL_MAC_SIGNED_EN
    // (-1)*2 * 4 = -8
    run_dot("neg", 32'hFFFF_FFFF, 32'h0202_0202, 1'b0, 18'h3FFF8);
`else
    // 255*2 * 4 = 2040
    run_dot("neg", 32'hFFFF_FFFF, 32'h0202_0202, 1'b0, 18'd2040);
`endif

    tick();
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    check("handoffs",   32'(handoffs),     32'd6);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/serial_word_mac.md
Name: serial_word_mac

Overview:
- Word-serial multiply-accumulate stage directly downstream of the N×M word shift register.
- Consumes one M-bit word per handshake, which is the low word the shift register presents each cycle. Multiplies it by a per-position coefficient and accumulates exactly N products into one dot-product result.
- Its accept strobe (in_valid && in_ready) drives the shift register's clock-enable, so one word is consumed per shift.

Parameters:
- N, 4, number of words per dot product (N >= 2).
- M, 8, bits per data word and per coefficient word.
- ACC_W, 2*M + $clog2(N), accumulator and result width (18 at defaults).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  begin a new dot product; sampled only in IDLE.
- coeff_data  input  N*M  coefficient vector; word k = coeff_data[k*M +: M]; latched on accepted start.
- in_valid  input  1  upstream word valid.
- in_data  input  M  upstream word; connects to the shift register's DOUT.
- in_ready  output  1  block accepts a word this cycle.
- out_valid  output  1  result valid.
- out_data  output  ACC_W  dot-product result.
- out_ready  input  1  downstream accepts the result.
- busy  output  1  high in ACCUM or DONE.

Behaviour:
- Reset: state=IDLE, acc=0, cnt=0, coeff_reg=0, out_data=0. Outputs in_ready, out_valid and busy are all 0. Reset applies immediately, including mid-operation; a partial result is discarded and never presented.
- States:
  - IDLE: in_ready=0, out_valid=0. start=1 latches coeff_data into coeff_reg, clears acc and cnt, and moves to ACCUM next cycle.
  - ACCUM: in_ready=1. A word is accepted when in_valid && in_ready; in_valid low inserts a stall cycle with no state change.
    - On accept: acc <= acc + in_data * coeff_reg[cnt], cnt <= cnt+1.
    - First accepted word pairs with coefficient word 0, k-th with word k.
    - On the accept with cnt==N-1: out_data <= final sum (including that product), out_valid <= 1, state <= DONE.
  - DONE: in_ready=0, out_valid=1. out_data is held stable while out_ready=0. On out_ready=1, out_valid drops next cycle and the block returns to IDLE.
- Latency: out_valid rises the cycle after the N-th accepted word.
- No back-to-back overlap: the earliest next start is sampled in the IDLE cycle after result hand-off.
- start asserted in ACCUM or DONE is ignored, and coeff_data is not re-latched. coeff_data changes after the latch have no effect.
- Arithmetic: unsigned by default. Products are M×M to 2M bits, zero-extended to ACC_W. ACC_W guarantees no overflow; the sum is not truncated.
- busy = (state != IDLE).
- in_data and coeff_data are don't-care whenever the respective strobe is not asserted.

Optional Feature:
- Macro: SERIAL_MAC_SIGNED_EN.
- Defined: in_data and coefficient words are two's complement. Products are signed 2M-bit, sign-extended to ACC_W. out_data is a signed ACC_W result.
- Not defined: all operands unsigned, zero-extended, as above.
- Handshake and timing are identical in both builds.

Test Plan:
- N=4, M=8, coeff words 0..3 = 1,2,3,4; stream 10,20,30,40 with in_valid continuous. Required: out_valid 1 cycle after 4th accept, out_data=300, in_ready=0 in DONE.
- Same vectors with in_valid low on alternate cycles. Required: only 4 accepts counted, out_data=300.
- All coeffs 255, all data 255. Required: out_data=260100 (no overflow in 18 bits).
- out_ready held low 5 cycles after result. Required: out_valid stays 1 and out_data stays constant. start pulsed in ACCUM and DONE is ignored. Returns to IDLE 1 cycle after out_ready=1.
- rst asserted after 2 accepted words. Required: immediate IDLE, all outputs 0. Next start with data 1,1,1,1 and coeffs 1,1,1,1 gives out_data=4.
- SERIAL_MAC_SIGNED_EN defined, all coeffs 0xFF (-1), all data 0x02. Required: out_data = -8 = 18'h3FFF8.
